// File: rtl/ms_timer_bank.sv
// ms_timer_bank: shared prescaler tick plus N_CH one-shot/periodic tick timers.
// Define TIMER_BANK_STICKY_EN to add clr_i, pending_o and overrun_o.
module ms_timer_bank #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int TICK_FREQ = 1_000,
   parameter int N_CH      = 4,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       start_i,
   input  logic [N_CH-1:0]       stop_i,
   input  logic [N_CH-1:0]       periodic_i,
   input  logic [N_CH*CNT_W-1:0] load_i,
   output logic                  tick_o,
   output logic [N_CH-1:0]       running_o,
   output logic [N_CH*CNT_W-1:0] count_o,
   output logic [N_CH-1:0]       expire_o
`ifdef TIMER_BANK_STICKY_EN
   ,
   input  logic [N_CH-1:0]       clr_i,
   output logic [N_CH-1:0]       pending_o,
   output logic [N_CH-1:0]       overrun_o
`endif
);

   localparam int DIV = CLK_FREQ / TICK_FREQ;
   localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

   if ((CLK_FREQ % TICK_FREQ) != 0 || DIV < 2 || N_CH < 1) begin : g_bad_cfg
      $error("ms_timer_bank: need CLK_FREQ/TICK_FREQ integral, >= 2, N_CH >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   logic [PW-1:0] pre_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         tick_o <= (pre_q == PW'(DIV - 1));
         if (pre_q == PW'(DIV - 1))
            pre_q <= '0;
         else
            pre_q <= pre_q + 1'b1;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      state_t           st_q;
      logic [CNT_W-1:0] per_q;
      logic [CNT_W-1:0] cnt_q;
      logic             mode_q;
      logic             exp_q;
      logic [CNT_W-1:0] load;

      assign load = load_i[k*CNT_W +: CNT_W];

      // restart beats stop, and both suppress a coincident expiry
      always_ff @(posedge clk) begin
         if (rst) begin
            st_q   <= IDLE;
            per_q  <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            exp_q  <= 1'b0;
         end else begin
            exp_q <= 1'b0;
            if (start_i[k] && load != '0) begin
               st_q   <= RUN;
               per_q  <= load;
               mode_q <= periodic_i[k];
               cnt_q  <= '0;
            end else if (stop_i[k]) begin
               st_q  <= IDLE;
               cnt_q <= '0;
            end else if (st_q == RUN && tick_o) begin
               if (cnt_q == per_q - 1'b1) begin
                  exp_q <= 1'b1;
                  if (mode_q) begin
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= per_q;
                     st_q  <= DONE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         end
      end

      assign running_o[k]                = (st_q == RUN);
      assign count_o[k*CNT_W +: CNT_W]   = cnt_q;
      assign expire_o[k]                 = exp_q;

`ifdef TIMER_BANK_STICKY_EN
      logic pend_q;
      logic ovr_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
         end else begin
            pend_q <= exp_q | (pend_q & ~clr_i[k]);
            ovr_q  <= (exp_q & pend_q) | (ovr_q & ~clr_i[k]);
         end
      end

      assign pending_o[k] = pend_q;
      assign overrun_o[k] = ovr_q;
`endif
   end

endmodule

// File: tb/tb_ms_timer_bank.sv
// Directed bench for ms_timer_bank: DIV=10, two 8-bit channels.
// Sticky flag checks are built when TIMER_BANK_STICKY_EN is defined.
module tb_ms_timer_bank;

   localparam int N_CH  = 2;
   localparam int CNT_W = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CH-1:0]       start_i;
   logic [N_CH-1:0]       stop_i;
   logic [N_CH-1:0]       periodic_i;
   logic [N_CH*CNT_W-1:0] load_i;
   logic                  tick_o;
   logic [N_CH-1:0]       running_o;
   logic [N_CH*CNT_W-1:0] count_o;
   logic [N_CH-1:0]       expire_o;
`ifdef TIMER_BANK_STICKY_EN
   logic [N_CH-1:0]       clr_i;
   logic [N_CH-1:0]       pending_o;
   logic [N_CH-1:0]       overrun_o;
`endif

   int n_chk = 0;
   int n_err = 0;

   ms_timer_bank #(
      .CLK_FREQ (10),
      .TICK_FREQ(1),
      .N_CH     (N_CH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .stop_i    (stop_i),
      .periodic_i(periodic_i),
      .load_i    (load_i),
      .tick_o    (tick_o),
      .running_o (running_o),
      .count_o   (count_o),
      .expire_o  (expire_o)
`ifdef TIMER_BANK_STICKY_EN
      ,
      .clr_i     (clr_i),
      .pending_o (pending_o),
      .overrun_o (overrun_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick_o && n < 40);
      if (!tick_o) check("tick_timeout", 32'(tick_o), 1);
   endtask

   function automatic logic [7:0] cnt(input int ch);
      return count_o[ch*CNT_W +: CNT_W];
   endfunction

   initial begin
      int n;
      int hits;
      rst        = 1'b1;
      start_i    = '0;
      stop_i     = '0;
      periodic_i = '0;
      load_i     = '0;
`ifdef TIMER_BANK_STICKY_EN
      clr_i      = '0;
`endif
      repeat (2) @(negedge clk);
      check("rst_tick", 32'(tick_o), 0);
      check("rst_run", 32'(running_o), 0);
      check("rst_cnt", 32'(count_o), 0);
      check("rst_exp", 32'(expire_o), 0);
`ifdef TIMER_BANK_STICKY_EN
      check("rst_pend", 32'(pending_o), 0);
      check("rst_ovr", 32'(overrun_o), 0);
`endif
      rst = 1'b0;

      // tick after edge 10 and 20 following release
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         check($sformatf("tick_c%0d", i), 32'(tick_o),
               32'((i == 10 || i == 20) ? 1 : 0));
      end

      // ch0 one-shot, period 3
      start_i = 2'b01;
      load_i  = {8'd0, 8'd3};
      @(negedge clk);
      start_i = '0;
      check("os_run", 32'(running_o[0]), 1);
      check("os_c0", 32'(cnt(0)), 0);
      wait_tick();
      @(negedge clk);
      check("os_c1", 32'(cnt(0)), 1);
      check("os_noexp", 32'(expire_o[0]), 0);
      wait_tick();
      @(negedge clk);
      check("os_c2", 32'(cnt(0)), 2);
      wait_tick();
      check("os_run_pre", 32'(running_o[0]), 1);
      @(negedge clk);
      check("os_exp", 32'(expire_o[0]), 1);
      check("os_c3", 32'(cnt(0)), 3);
      check("os_run_fall", 32'(running_o[0]), 0);
      check("os_ch1_run", 32'(running_o[1]), 0);
      check("os_ch1_cnt", 32'(cnt(1)), 0);
      @(negedge clk);
      check("os_exp_1cyc", 32'(expire_o[0]), 0);
      check("os_hold", 32'(cnt(0)), 3);

      // ch1 periodic, period 2
      start_i    = 2'b10;
      periodic_i = 2'b10;
      load_i     = {8'd2, 8'd0};
      @(negedge clk);
      start_i = '0;
      check("per_c0", 32'(cnt(1)), 0);
      wait_tick();
      @(negedge clk);
      check("per_c1", 32'(cnt(1)), 1);
      wait_tick();
      @(negedge clk);
      check("per_exp", 32'(expire_o[1]), 1);
      check("per_wrap", 32'(cnt(1)), 0);
      check("per_run", 32'(running_o[1]), 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!expire_o[1] && n < 50);
      check("per_gap", 32'(n), 20);
      check("per_wrap2", 32'(cnt(1)), 0);
      stop_i = 2'b10;
      @(negedge clk);
      stop_i = '0;
      check("stop_run", 32'(running_o[1]), 0);
      check("stop_cnt", 32'(cnt(1)), 0);
      hits = 0;
      repeat (30) begin
         @(negedge clk);
         if (expire_o[1]) hits++;
      end
      check("stop_noexp", 32'(hits), 0);

      // stop on the expiring tick
      start_i    = 2'b01;
      periodic_i = 2'b00;
      load_i     = {8'd0, 8'd1};
      @(negedge clk);
      start_i = '0;
      wait_tick();
      stop_i = 2'b01;
      @(negedge clk);
      stop_i = '0;
      check("stopexp_exp", 32'(expire_o[0]), 0);
      check("stopexp_run", 32'(running_o[0]), 0);
      check("stopexp_cnt", 32'(cnt(0)), 0);

      // start+stop together: restart
      start_i = 2'b01;
      stop_i  = 2'b01;
      load_i  = {8'd0, 8'd5};
      @(negedge clk);
      start_i = '0;
      stop_i  = '0;
      check("ss_run", 32'(running_o[0]), 1);
      check("ss_cnt", 32'(cnt(0)), 0);
      wait_tick();
      @(negedge clk);
      check("ss_c1", 32'(cnt(0)), 1);

      // start with load 0 is ignored
      start_i = 2'b01;
      load_i  = '0;
      @(negedge clk);
      start_i = '0;
      check("ld0_run", 32'(running_o[0]), 1);
      check("ld0_cnt", 32'(cnt(0)), 1);

      // reset mid-run at count 2, coinciding with a tick
      start_i    = 2'b10;
      periodic_i = 2'b10;
      load_i     = {8'd3, 8'd0};
      @(negedge clk);
      start_i = '0;
      wait_tick();
      @(negedge clk);
      check("mr_c2", 32'(cnt(0)), 2);
      wait_tick();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_run", 32'(running_o), 0);
      check("mr_cnt", 32'(count_o), 0);
      check("mr_exp", 32'(expire_o), 0);
      check("mr_tick", 32'(tick_o), 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick_o && n < 40);
      check("mr_first_tick", 32'(n), 10);

`ifdef TIMER_BANK_STICKY_EN
      start_i    = 2'b01;
      periodic_i = 2'b01;
      load_i     = {8'd0, 8'd1};
      @(negedge clk);
      start_i = '0;
      wait_tick();
      @(negedge clk);
      check("st_exp1", 32'(expire_o[0]), 1);
      @(negedge clk);
      check("st_pend1", 32'(pending_o[0]), 1);
      check("st_ovr1", 32'(overrun_o[0]), 0);
      wait_tick();
      @(negedge clk);
      @(negedge clk);
      check("st_pend2", 32'(pending_o[0]), 1);
      check("st_ovr2", 32'(overrun_o[0]), 1);
      clr_i = 2'b01;
      @(negedge clk);
      clr_i = '0;
      check("st_clr_pend", 32'(pending_o[0]), 0);
      check("st_clr_ovr", 32'(overrun_o[0]), 0);
      wait_tick();
      @(negedge clk);
      @(negedge clk);
      check("st_pend3", 32'(pending_o[0]), 1);
      check("st_ovr3", 32'(overrun_o[0]), 0);
      wait_tick();
      @(negedge clk);
      check("st_exp4", 32'(expire_o[0]), 1);
      clr_i = 2'b01;
      @(negedge clk);
      clr_i = '0;
      check("st_setwin_pend", 32'(pending_o[0]), 1);
      check("st_setwin_ovr", 32'(overrun_o[0]), 1);
      stop_i = 2'b01;
      @(negedge clk);
      stop_i = '0;
      @(negedge clk);
      check("st_stop_pend", 32'(pending_o[0]), 1);
      check("st_stop_ovr", 32'(overrun_o[0]), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
